// File: rtl/hcsr04_ranger.sv
// hcsr04_ranger: time-multiplexed ultrasonic ranging controller for HC-SR04-class sensors.
// It fires one trigger at a time, times the echo on the selected channel, and converts the
// echo width to centimetres by counting 58 us slices instead of dividing.
//
// Ports:
//   clk         system clock
//   btn_reset   synchronous active-high reset
//   enable      allows new measurements to start
//   mode        0 = continuous round-robin, 1 = on-demand via start
//   start       one-cycle request, honoured only in IDLE with mode 1
//   thresh_cm   proximity threshold shared by all channels
//   echo        raw asynchronous echo pins, one per channel
//   trigger     trigger pins, one-hot or zero
//   busy        high whenever the controller is not idle
//   dist_valid  one-cycle result strobe
//   dist_ch     channel of the latest result
//   dist_cm     latest distance (saturates at MAX_CM)
//   timeout     latest result was a rise timeout or a saturation
//   near        per-channel proximity flags
module hcsr04_ranger #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned N_CH       = 2,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned RISE_TO_US = 2000,
  parameter int unsigned GAP_US     = 60000,
  parameter int unsigned MAX_CM     = 400,
  parameter int unsigned CM_W       = 9,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            btn_reset,
  input  logic            enable,
  input  logic            mode,
  input  logic            start,
  input  logic [CM_W-1:0] thresh_cm,
  input  logic [N_CH-1:0] echo,
  output logic [N_CH-1:0] trigger,
  output logic            busy,
  output logic            dist_valid,
  output logic [CH_W-1:0] dist_ch,
  output logic [CM_W-1:0] dist_cm,
  output logic            timeout,
  output logic [N_CH-1:0] near
);

  localparam int unsigned US_CYC   = CLK_HZ / 1_000_000;
  localparam int unsigned TRIG_CYC = TRIG_US * US_CYC;
  localparam int unsigned RISE_CYC = RISE_TO_US * US_CYC;
  localparam int unsigned GAP_CYC  = GAP_US * US_CYC;
  localparam int unsigned SUB_CYC  = 58 * US_CYC;
  localparam int unsigned MAX_A    = (TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC;
  localparam int unsigned CNT_MAX  = (MAX_A > RISE_CYC) ? MAX_A : RISE_CYC;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned SUB_W    = $clog2(SUB_CYC);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StGap
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [CM_W-1:0]  cm_q, cm_d;
  logic [CH_W-1:0]  ch_q, ch_d;

  logic [N_CH-1:0] echo_s1_q, echo_s2_q, echo_s3_q;
  logic [N_CH-1:0] echo_rise, echo_fall;

  logic [N_CH-1:0] trigger_q, trig_sel;
  logic            dist_valid_q, timeout_q;
  logic [CH_W-1:0] dist_ch_q;
  logic [CM_W-1:0] dist_cm_q;
  logic [N_CH-1:0] near_q;

  logic            rep, rep_to;
  logic [CM_W-1:0] rep_cm;
  logic            sub_wrap;
  logic [CM_W-1:0] cm_inc;

  // echo_s1/s2 form the synchronizer; s3 only delays s2 for edge detection.
  assign echo_rise = echo_s2_q & ~echo_s3_q;
  assign echo_fall = ~echo_s2_q & echo_s3_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    cm_d     = cm_q;
    ch_d     = ch_q;
    rep      = 1'b0;
    rep_to   = 1'b0;
    rep_cm   = '0;
    trig_sel = '0;
    trig_sel[ch_q] = 1'b1;
    sub_wrap = (sub_q == SUB_W'(SUB_CYC - 1));
    // cm including the slice that completes this cycle, so the fall cycle is counted too.
    cm_inc   = sub_wrap ? cm_q + 1'b1 : cm_q;

    unique case (state_q)
      StIdle: begin
        if (enable && (!mode || start)) begin
          state_d = StTrig;
          cnt_d   = '0;
        end
      end
      StTrig: begin
        if (cnt_q == CNT_W'(TRIG_CYC - 1)) begin
          state_d = StWaitRise;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitRise: begin
        if (echo_rise[ch_q]) begin
          state_d = StMeasure;
          sub_d   = '0;
          cm_d    = '0;
        end else if (cnt_q == CNT_W'(RISE_CYC)) begin
          // Entered one cycle before the trigger pin falls, hence RISE_CYC rather than -1.
          rep     = 1'b1;
          rep_to  = 1'b1;
          rep_cm  = CM_W'(MAX_CM);
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StMeasure: begin
        sub_d = sub_wrap ? '0 : sub_q + 1'b1;
        cm_d  = cm_inc;
        if (cm_inc == CM_W'(MAX_CM)) begin
          rep     = 1'b1;
          rep_to  = 1'b1;
          rep_cm  = CM_W'(MAX_CM);
          state_d = StGap;
          cnt_d   = '0;
        end else if (echo_fall[ch_q]) begin
          rep     = 1'b1;
          rep_cm  = cm_inc;
          state_d = StGap;
          cnt_d   = '0;
        end
      end
      StGap: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          ch_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
          state_d = (!mode && enable) ? StTrig : StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (btn_reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sub_q        <= '0;
      cm_q         <= '0;
      ch_q         <= '0;
      echo_s1_q    <= '0;
      echo_s2_q    <= '0;
      echo_s3_q    <= '0;
      trigger_q    <= '0;
      dist_valid_q <= 1'b0;
      dist_ch_q    <= '0;
      dist_cm_q    <= '0;
      timeout_q    <= 1'b0;
      near_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sub_q        <= sub_d;
      cm_q         <= cm_d;
      ch_q         <= ch_d;
      echo_s1_q    <= echo;
      echo_s2_q    <= echo_s1_q;
      echo_s3_q    <= echo_s2_q;
      trigger_q    <= (state_q == StTrig) ? trig_sel : '0;
      dist_valid_q <= rep;
      if (rep) begin
        dist_ch_q    <= ch_q;
        dist_cm_q    <= rep_cm;
        timeout_q    <= rep_to;
        // A zero threshold can never satisfy the strict compare, so the flag clears.
        near_q[ch_q] <= !rep_to && (rep_cm < thresh_cm);
      end
    end
  end

  assign trigger    = trigger_q;
  assign busy       = (state_q != StIdle);
  assign dist_valid = dist_valid_q;
  assign dist_ch    = dist_ch_q;
  assign dist_cm    = dist_cm_q;
  assign timeout    = timeout_q;
  assign near       = near_q;

endmodule
